// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared helpers for seq_detector (clog2, KMP transition/border generation, N limits).
package seq_det_pkg;
   localparam int N_MIN = 2;
   localparam int N_MAX = 8;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
   // Longest proper prefix of pat that is a suffix of (prefix of length s, then bit b).
   // pat[n-1] is the first pattern bit; w[j] is the j-th bit of the candidate string.
   function automatic int kmp_next(input logic [N_MAX-1:0] pat, input int n, input int s, input logic b);
      logic [N_MAX-1:0] w;
      logic ok;
      int best;
      w = '0;
      best = 0;
      for (int j = 0; j < N_MAX; j++) begin
         if (j < s) w[j] = pat[n-1-j];
         else if (j == s) w[j] = b;
      end
      for (int k = 1; k < N_MAX; k++) begin
         ok = (k <= s + 1) && (k < n);
         for (int j = 0; j < N_MAX; j++) if (ok && j < k && w[s+1-k+j] != pat[n-1-j]) ok = 1'b0;
         if (ok) best = k;
      end
      return best;
   endfunction
   function automatic int border(input logic [N_MAX-1:0] pat, input int n);
      return kmp_next(pat, n, n - 1, pat[0]);
   endfunction
endpackage

// File: rtl/seq_det_next.sv
// seq_det_next: combinational KMP next-state and match decode, table built at elaboration.
module seq_det_next
   import seq_det_pkg::*;
#(
   parameter int N = 4,
   parameter logic [N-1:0] PATTERN = 4'b1011,
   parameter int OVERLAP = 1,
   parameter int SW = 2
) (
   input  logic [SW-1:0] state,
   input  logic          in_valid,
   input  logic          in_bit,
   output logic [SW-1:0] state_nxt,
   output logic          match_nxt
);
   localparam logic [N_MAX-1:0] PAT = N_MAX'(PATTERN);
   localparam logic [SW-1:0] RESTART = (OVERLAP != 0) ? SW'(border(PAT, N)) : '0;
   logic [SW-1:0] tbl [2**SW][2];
   logic hit;
   for (genvar s = 0; s < 2**SW; s++) begin : g_s
      for (genvar b = 0; b < 2; b++) begin : g_b
         if (s < N) begin : g_live
            assign tbl[s][b] = SW'(kmp_next(PAT, N, s, b[0]));
         end else begin : g_dead
            assign tbl[s][b] = '0;
         end
      end
   end
   always_comb begin
      hit = in_valid && state == SW'(N - 1) && in_bit == PATTERN[0];
      match_nxt = hit;
      state_nxt = !in_valid ? state : hit ? RESTART : tbl[state][in_bit];
   end
endmodule

// File: rtl/seq_detector.sv
// seq_detector: serial KMP pattern detector with registered match pulse.
// Define SEQ_DETECTOR_COUNT_EN to add the saturating match_count port and counter.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int N = 4,
   parameter logic [N-1:0] PATTERN = 4'b1011,
   parameter int OVERLAP = 1,
   parameter int CNT_W = 8,
   localparam int SW = clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             match,
   output logic [SW-1:0]    state
`ifdef SEQ_DETECTOR_COUNT_EN
   ,
   output logic [CNT_W-1:0] match_count
`endif
);
   if (N < N_MIN || N > N_MAX) begin : g_bad_n
      $error("seq_detector: N out of range 2..8");
   end
   logic [SW-1:0] state_nxt;
   logic match_nxt;
   seq_det_next #(.N(N), .PATTERN(PATTERN), .OVERLAP(OVERLAP), .SW(SW)) u_next (
      .state(state),
      .in_valid(in_valid),
      .in_bit(in_bit),
      .state_nxt(state_nxt),
      .match_nxt(match_nxt)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
         match <= 1'b0;
      end else begin
         state <= state_nxt;
         match <= match_nxt;
      end
   end
`ifdef SEQ_DETECTOR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) match_count <= '0;
      else if (match_nxt && match_count != '1) match_count <= match_count + 1'b1;
   end
`endif
endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the pattern length in bits (legal 2..8).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, N bits wide, with PATTERN[N-1] as the first bit expected.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = restart after each match.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-005 Port clk, input, 1 bit: the single clock, rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port in_valid, input, 1 bit: qualifies in_bit in the current cycle.
REQ-008 Port in_bit, input, 1 bit: serial data bit.
REQ-009 Port match, output, 1 bit: registered one-cycle pulse indicating a completed pattern.
REQ-010 Port state, output, SW = clog2(N) bits: current matched-prefix length, 0..N-1.
REQ-011 Port match_count, output, CNT_W bits: saturating count of matches (present only when counting is compiled in, per REQ-024).

Function
REQ-012 The state SHALL equal the length of the longest proper prefix of PATTERN that is a suffix of the accepted bits (KMP automaton); the transition table SHALL be derived from PATTERN at elaboration.
REQ-013 A bit is accepted only on a rising edge with in_valid=1; with in_valid=0, state SHALL hold and match SHALL be 0 in the next cycle.
REQ-014 An accepted bit that completes the pattern (state=N-1 and in_bit=PATTERN[0]) SHALL set match=1 for exactly the following cycle (latency 1 clock); there is no combinational path from inputs to match.
REQ-015 After a match, the next state SHALL be the longest proper border of PATTERN when OVERLAP=1, and 0 when OVERLAP=0.
REQ-016 A non-completing accepted bit SHALL move state to the KMP transition target, never exceeding N-1.
REQ-017 Back-to-back matches SHALL produce match high on consecutive cycles where the pattern allows it (e.g. PATTERN=3'b111, OVERLAP=1).
REQ-018 match_count SHALL increment by 1 in the same cycle that match rises and SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-019 With rst=1 at a rising edge: state=0, match=0, match_count=0.
REQ-020 rst SHALL take priority over in_valid; a bit presented in the reset cycle SHALL be discarded.
REQ-021 Reset mid-pattern SHALL discard the partial prefix; a match pending in that cycle SHALL be suppressed.

Configuration
REQ-022 Macro SEQ_DETECTOR_COUNT_EN SHALL control the match counter.
REQ-023 With SEQ_DETECTOR_COUNT_EN defined: the match_count port and its counter SHALL exist per REQ-018.
REQ-024 Without SEQ_DETECTOR_COUNT_EN: the match_count port and its counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-025 Package seq_det_pkg SHALL hold the clog2 function, the border/transition-table generation function, and the parameter legality constants (N_MIN=2, N_MAX=8).
REQ-026 Combinational next-state/match logic SHALL live in sub-module seq_det_next; seq_detector SHALL hold only the registers.
REQ-027 Illegal N (outside 2..8) SHALL fail elaboration.

Verification
REQ-028 Bench SHALL drive defaults, OVERLAP=1, bits 1,0,1,1,0,1,1 on consecutive valid cycles -> match pulses after bit 4 and bit 7; match_count=2.
REQ-029 Bench SHALL drive the same stream with OVERLAP=0 -> single match after bit 4; state=1 after bit 7; match_count=1.
REQ-030 Bench SHALL drive 1,0, then in_valid=0 for 3 cycles with in_bit toggling, then 1,1 -> state holds at 2 during the gap; exactly one match.
REQ-031 Bench SHALL drive 1,0,1, then rst=1 for one cycle with in_valid=1 and in_bit=1, then 1 -> state=0 after reset, state=1 after the next bit, no match.
REQ-032 Bench SHALL use PATTERN=3'b111, N=3, OVERLAP=1, with five consecutive 1s -> match high on 3 consecutive cycles, following bits 3, 4 and 5.
REQ-033 Bench SHALL use CNT_W=2 with COUNT_EN defined and 5 matches -> match_count=3 held after the third match; bench SHALL also build without the macro and re-run REQ-028 with the counter check omitted.
